// File: rtl/conv_sequencer.sv
// Raster-order controller for the load/shift/convolve datapath: handshakes each
// unit in turn and writes every 16-bit convolution result to a result RAM.
module conv_sequencer #(
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128,
   parameter int FILTER_SIZE  = 3,
   parameter int OUT_W        = IMAGE_WIDTH - FILTER_SIZE + 1,
   parameter int OUT_H        = IMAGE_HEIGHT - FILTER_SIZE + 1,
   parameter int CNT_W        = 8,
   parameter int ADDR_W       = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              load_req,
   output logic [CNT_W-1:0]  load_row,
   input  logic              load_ack,
   output logic              shift_req,
   output logic [CNT_W-1:0]  shift_col,
   input  logic              shift_ack,
   output logic              conv_req,
   input  logic              conv_ack,
   input  logic [15:0]       conv_result,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   input  logic              wr_ready,
   output logic [CNT_W-1:0]  out_row,
   output logic [CNT_W-1:0]  out_col
);

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_CONV,
      S_STORE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    row_q, row_d;
   logic [CNT_W-1:0]    col_q, col_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                load_req_q, load_req_d;
   logic                shift_req_q, shift_req_d;
   logic                conv_req_q, conv_req_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [15:0]         wr_data_q, wr_data_d;

   // Each req is asserted on entry to its state and dropped on the accepting edge,
   // so an ack seen outside that window can never advance the sequence.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load_req_d  = load_req_q;
      shift_req_d = shift_req_q;
      conv_req_d  = conv_req_q;
      wr_en_d     = wr_en_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d    = S_LOAD;
               row_d      = '0;
               col_d      = '0;
               busy_d     = 1'b1;
               load_req_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (load_ack) begin
               state_d     = S_SHIFT;
               load_req_d  = 1'b0;
               shift_req_d = 1'b1;
            end
         end
         S_SHIFT: begin
            if (shift_ack) begin
               state_d     = S_CONV;
               shift_req_d = 1'b0;
               conv_req_d  = 1'b1;
            end
         end
         S_CONV: begin
            if (conv_ack) begin
               state_d    = S_STORE;
               conv_req_d = 1'b0;
               wr_en_d    = 1'b1;
               wr_data_d  = conv_result;
               wr_addr_d  = ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);
            end
         end
         S_STORE: begin
            if (wr_ready) begin
               wr_en_d = 1'b0;
               if (col_q != LAST_COL) begin
                  state_d     = S_SHIFT;
                  col_d       = col_q + 1'b1;
                  shift_req_d = 1'b1;
               end else if (row_q != LAST_ROW) begin
                  state_d    = S_LOAD;
                  row_d      = row_q + 1'b1;
                  col_d      = '0;
                  load_req_d = 1'b1;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort outranks any ack in the same cycle.
      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         row_d       = '0;
         col_d       = '0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         load_req_d  = 1'b0;
         shift_req_d = 1'b0;
         conv_req_d  = 1'b0;
         wr_en_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_req_q  <= 1'b0;
         shift_req_q <= 1'b0;
         conv_req_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_req_q  <= load_req_d;
         shift_req_q <= shift_req_d;
         conv_req_q  <= conv_req_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign load_req  = load_req_q;
   assign load_row  = row_q;
   assign shift_req = shift_req_q;
   assign shift_col = col_q;
   assign conv_req  = conv_req_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign out_row   = row_q;
   assign out_col   = col_q;

endmodule
